// File: rtl/ddr_rx_pkg.sv
// Shared constants and types for the DDR receive gearbox.
// Word width, bits per DDR beat and the FIFO entry type live here.
package ddr_rx_pkg;

  localparam int WORD_W = 8;
  localparam int BEAT_W = 2;

  typedef logic [WORD_W-1:0] fifo_entry_t;

endpackage

// File: rtl/ddr_rx_gearbox_if.sv
// Bus bundle for ddr_rx_gearbox: DDR beat input side and word output handshake.
// The slave modport is the gearbox view, the master modport is the source/sink view.
interface ddr_rx_gearbox_if;
  import ddr_rx_pkg::*;

  logic        in_valid;
  logic        Q0;
  logic        Q1;
  logic        bitslip;
  fifo_entry_t out_data;
  logic        out_valid;
  logic        out_ready;

  modport slave (
    input  in_valid, Q0, Q1, bitslip, out_ready,
    output out_data, out_valid
  );

  modport master (
    output in_valid, Q0, Q1, bitslip, out_ready,
    input  out_data, out_valid
  );

endinterface

// File: rtl/ddr_rx_word_fifo.sv
// Word FIFO with registered head: out_data/out_valid come straight from flops.
// A push into a full FIFO is accepted only when the head is popped in the same cycle.
module ddr_rx_word_fifo
  import ddr_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        SCLK,
  input  logic        RST,
  input  logic        in_valid,
  output logic        in_ready,
  input  fifo_entry_t in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output fifo_entry_t out_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fifo_entry_t      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_next;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  fifo_entry_t      head_next;
  fifo_entry_t      out_data_reg;
  logic             out_valid_reg;
  logic             full;
  logic             push;
  logic             pop;

  assign full        = (count_reg == CNT_W'(FIFO_DEPTH));
  assign pop         = out_valid_reg && out_ready;
  assign in_ready    = !full || pop;
  assign push        = in_valid && in_ready;
  assign rd_ptr_next = rd_ptr_reg + PTR_W'(pop);

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CNT_W'(1);
    end else if (!push && pop) begin
      count_next = count_reg - CNT_W'(1);
    end
    // When the new head slot is the one being written now, bypass the array.
    if (push && (wr_ptr_reg == rd_ptr_next)) begin
      head_next = in_data;
    end else begin
      head_next = mem[rd_ptr_next];
    end
  end

  always_ff @(posedge SCLK) begin
    if (push) begin
      mem[wr_ptr_reg] <= in_data;
    end
  end

  always_ff @(posedge SCLK or posedge RST) begin
    if (RST) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      out_valid_reg <= (count_next != '0);
      if (count_next != '0) begin
        out_data_reg <= head_next;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

endmodule

// File: rtl/ddr_rx_gearbox.sv
// DDR 2-bit-per-beat to 8-bit word gearbox with output FIFO and sticky overflow.
// Define DDR_RX_GEARBOX_BITSLIP_EN to enable word-boundary bitslip (10-bit shift register).
module ddr_rx_gearbox
  import ddr_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic              SCLK,
  input  logic              RST,
  ddr_rx_gearbox_if.slave   bus,
  input  logic              clr_ovf,
  output logic              overflow
);

`ifdef DDR_RX_GEARBOX_BITSLIP_EN
  localparam int SR_W = WORD_W + BEAT_W;
`else
  localparam int SR_W = WORD_W;
`endif

  logic [SR_W-1:0] sr_reg;
  logic [SR_W-1:0] sr_next;
  logic [SR_W-1:0] sr_shift;
  logic [3:0]      cnt_reg;
  logic [3:0]      cnt_next;
  logic [3:0]      cnt_sum;
  fifo_entry_t     word;
  logic            word_valid;
  logic            fifo_in_ready;
  logic            fifo_out_valid;
  fifo_entry_t     fifo_out_data;
  logic            overflow_reg;
`ifdef DDR_RX_GEARBOX_BITSLIP_EN
  logic            slip_reg;
  logic            slip_next;
`endif

  always_comb begin
    sr_next    = sr_reg;
    sr_shift   = sr_reg;
    cnt_next   = cnt_reg;
    cnt_sum    = cnt_reg;
    word       = '0;
    word_valid = 1'b0;
`ifdef DDR_RX_GEARBOX_BITSLIP_EN
    slip_next  = slip_reg;
    if (bus.bitslip) begin
      slip_next = 1'b1;
    end
    if (bus.in_valid) begin
      // A pending or same-cycle slip drops Q0, delaying the boundary by one bit.
      if (slip_reg || bus.bitslip) begin
        sr_shift  = {sr_reg[SR_W-2:0], bus.Q1};
        cnt_sum   = cnt_reg + 4'd1;
        slip_next = 1'b0;
      end else begin
        sr_shift = {sr_reg[SR_W-3:0], bus.Q0, bus.Q1};
        cnt_sum  = cnt_reg + 4'd2;
      end
    end
`else
    if (bus.in_valid) begin
      sr_shift = {sr_reg[SR_W-3:0], bus.Q0, bus.Q1};
      cnt_sum  = cnt_reg + 4'd2;
    end
`endif
    if (bus.in_valid) begin
      sr_next  = sr_shift;
      cnt_next = cnt_sum;
      if (cnt_sum >= 4'd8) begin
        word_valid = 1'b1;
        cnt_next   = cnt_sum - 4'd8;
`ifdef DDR_RX_GEARBOX_BITSLIP_EN
        // With nine bits held, the newest one is the leftover for the next word.
        word = cnt_sum[0] ? sr_shift[WORD_W:1] : sr_shift[WORD_W-1:0];
`else
        word = sr_shift;
`endif
      end
    end
  end

  always_ff @(posedge SCLK or posedge RST) begin
    if (RST) begin
      sr_reg       <= '0;
      cnt_reg      <= '0;
      overflow_reg <= 1'b0;
`ifdef DDR_RX_GEARBOX_BITSLIP_EN
      slip_reg     <= 1'b0;
`endif
    end else begin
      sr_reg  <= sr_next;
      cnt_reg <= cnt_next;
`ifdef DDR_RX_GEARBOX_BITSLIP_EN
      slip_reg <= slip_next;
`endif
      // A drop in the same cycle as clr_ovf wins so no event is lost.
      if (word_valid && !fifo_in_ready) begin
        overflow_reg <= 1'b1;
      end else if (clr_ovf) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  ddr_rx_word_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .SCLK      (SCLK),
    .RST       (RST),
    .in_valid  (word_valid),
    .in_ready  (fifo_in_ready),
    .in_data   (word),
    .out_valid (fifo_out_valid),
    .out_ready (bus.out_ready),
    .out_data  (fifo_out_data)
  );

  assign bus.out_valid = fifo_out_valid;
  assign bus.out_data  = fifo_out_data;
  assign overflow      = overflow_reg;

endmodule

// File: tb/tb_ddr_rx_gearbox.sv
// Self-checking bench for ddr_rx_gearbox: bit-queue reference model plus directed scenarios.
// Honours DDR_RX_GEARBOX_BITSLIP_EN to match the DUT build.
module tb_ddr_rx_gearbox;

  localparam int FIFO_DEPTH = 2;

  logic SCLK;
  logic RST;
  logic clr_ovf;
  logic overflow;

  ddr_rx_gearbox_if bus ();

  ddr_rx_gearbox #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .SCLK     (SCLK),
    .RST      (RST),
    .bus      (bus),
    .clr_ovf  (clr_ovf),
    .overflow (overflow)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: bits in arrival order, words awaiting the consumer, sticky flag.
  bit         m_bits[$];
  logic [7:0] m_fifo[$];
  bit         m_ovf;
  bit         m_slip;

  initial begin
    SCLK = 1'b0;
    forever #5 SCLK = ~SCLK;
  end

  task automatic model_clear();
    m_bits.delete();
    m_fifo.delete();
    m_ovf  = 1'b0;
    m_slip = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.Q0        = 1'b0;
    bus.Q1        = 1'b0;
    bus.bitslip   = 1'b0;
    bus.out_ready = 1'b0;
    clr_ovf       = 1'b0;
  endtask

  // One clock: drive inputs, advance the model by the edge, then compare outputs.
  task automatic step(input bit v, input bit q0, input bit q1, input bit bs,
                      input bit rdy, input bit clr, input string tag);
    int         occ;
    bit         pop;
    bit         have_w;
    bit         ovf_evt;
    logic [7:0] w;
    bus.in_valid  = v;
    bus.Q0        = q0;
    bus.Q1        = q1;
    bus.bitslip   = bs;
    bus.out_ready = rdy;
    clr_ovf       = clr;
    @(posedge SCLK);
    occ     = m_fifo.size();
    pop     = (occ > 0) && rdy;
    have_w  = 1'b0;
    ovf_evt = 1'b0;
    w       = 8'h00;
`ifdef DDR_RX_GEARBOX_BITSLIP_EN
    if (bs) m_slip = 1'b1;
    if (v) begin
      if (m_slip) begin
        m_bits.push_back(q1);
        m_slip = 1'b0;
      end else begin
        m_bits.push_back(q0);
        m_bits.push_back(q1);
      end
    end
`else
    if (v) begin
      m_bits.push_back(q0);
      m_bits.push_back(q1);
    end
`endif
    if (m_bits.size() >= 8) begin
      for (int i = 0; i < 8; i++) w = {w[6:0], m_bits.pop_front()};
      have_w = 1'b1;
    end
    if (pop) begin
      $display("[%s] word %02h accepted", tag, m_fifo[0]);
      void'(m_fifo.pop_front());
    end
    if (have_w) begin
      if (occ < FIFO_DEPTH || pop) m_fifo.push_back(w);
      else begin
        ovf_evt = 1'b1;
        m_ovf   = 1'b1;
        $display("[%s] word %02h dropped", tag, w);
      end
    end
    if (!ovf_evt && clr) m_ovf = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== (m_fifo.size() > 0)) begin
      errors++;
      $display("FAIL %s out_valid got %b exp %b", tag, bus.out_valid, m_fifo.size() > 0);
    end
    if (m_fifo.size() > 0) begin
      checks++;
      if (bus.out_data !== m_fifo[0]) begin
        errors++;
        $display("FAIL %s out_data got %02h exp %02h", tag, bus.out_data, m_fifo[0]);
      end
    end
    checks++;
    if (overflow !== m_ovf) begin
      errors++;
      $display("FAIL %s overflow got %b exp %b", tag, overflow, m_ovf);
    end
  endtask

  task automatic apply_reset();
    idle_inputs();
    RST = 1'b1;
    model_clear();
    @(posedge SCLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset out_valid got %b exp 0", bus.out_valid);
    end
    checks++;
    if (bus.out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset out_data got %02h exp 00", bus.out_data);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset overflow got %b exp 0", overflow);
    end
  endtask

  task automatic test_basic_word();
    apply_reset();
    step(1, 1, 0, 0, 1, 0, "basic");
    step(1, 1, 0, 0, 1, 0, "basic");
    step(1, 0, 1, 0, 1, 0, "basic");
    step(1, 0, 1, 0, 1, 0, "basic");
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5) begin
      errors++;
      $display("FAIL basic_a5 got v=%b d=%02h exp v=1 d=a5", bus.out_valid, bus.out_data);
    end
    step(0, 0, 0, 0, 1, 0, "basic");
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_one_cycle out_valid got %b exp 0", bus.out_valid);
    end
  endtask

  task automatic test_bitslip();
    apply_reset();
    step(0, 0, 0, 1, 1, 0, "bitslip");
    step(1, 0, 1, 0, 1, 0, "bitslip");
    step(1, 0, 1, 0, 1, 0, "bitslip");
    step(1, 1, 0, 0, 1, 0, "bitslip");
    step(1, 1, 0, 0, 1, 0, "bitslip");
    step(1, 1, 0, 0, 1, 0, "bitslip");
    // Leftover bit alignment shows up in the following words.
    for (int i = 0; i < 8; i++) step(1, i[0], i[1], 0, 1, 0, "bitslip_tail");
    // Same-cycle slip plus a second pulse while pending.
    step(1, 1, 1, 1, 1, 0, "bitslip_same");
    step(0, 0, 0, 1, 1, 0, "bitslip_twice");
    step(0, 0, 0, 1, 1, 0, "bitslip_twice");
    for (int i = 0; i < 10; i++) step(1, i[1], i[0], 0, 1, 0, "bitslip_after");
    step(0, 0, 0, 0, 1, 0, "bitslip_after");
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 12; i++) step(1, 1, 1, 0, 0, 0, "ovf_fill");
    checks++;
    if (overflow !== 1'b1 || bus.out_data !== 8'hFF) begin
      errors++;
      $display("FAIL ovf_set got ovf=%b d=%02h exp ovf=1 d=ff", overflow, bus.out_data);
    end
    step(0, 0, 0, 0, 0, 1, "ovf_clr");
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr overflow got %b exp 0", overflow);
    end
    // Clear coincident with a fresh drop must leave the flag set.
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, 0, "ovf_again");
    step(1, 0, 1, 0, 0, 1, "ovf_clr_coincident");
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_clr_coincident overflow got %b exp 1", overflow);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, "ovf_drain");
  endtask

  task automatic test_full_pop();
    int delivered;
    apply_reset();
    for (int i = 0; i < 11; i++) step(1, 1, 1, 0, 0, 0, "full_fill");
    step(1, 1, 1, 0, 1, 0, "full_pop_push");
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_push overflow got %b exp 0", overflow);
    end
    delivered = 1;
    for (int i = 0; i < 4; i++) begin
      if (bus.out_valid === 1'b1) delivered++;
      step(0, 0, 0, 0, 1, 0, "full_drain");
    end
    checks++;
    if (delivered != 3) begin
      errors++;
      $display("FAIL full_delivered got %0d exp 3", delivered);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 0, "arst_fill");
    step(1, 1, 1, 0, 0, 0, "arst_partial");
    step(1, 1, 1, 0, 0, 0, "arst_partial");
    idle_inputs();
    RST = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL arst_immediate got v=%b d=%02h ovf=%b exp 0/00/0",
               bus.out_valid, bus.out_data, overflow);
    end
    model_clear();
    #2;
    RST = 1'b0;
    @(posedge SCLK);
    #1;
    step(1, 0, 0, 0, 1, 0, "arst_word");
    step(1, 0, 0, 0, 1, 0, "arst_word");
    step(1, 0, 0, 0, 1, 0, "arst_word");
    step(1, 0, 1, 0, 1, 0, "arst_word");
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h01) begin
      errors++;
      $display("FAIL arst_word got v=%b d=%02h exp v=1 d=01", bus.out_valid, bus.out_data);
    end
    step(0, 0, 0, 0, 1, 0, "arst_word");
  endtask

  task automatic test_gaps();
    apply_reset();
    for (int p = 0; p < 16; p++) begin
      step(1, 1'($urandom), 1'($urandom), 0, 1, 0, "gaps");
      for (int g = 0; g < 3; g++) step(0, 1'($urandom), 1'($urandom), 0, 1, 0, "gaps_idle");
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 19) == 0), "random");
    end
  endtask

  initial begin
    RST = 1'b1;
    idle_inputs();
    model_clear();
    test_reset();
    test_basic_word();
    test_bitslip();
    test_overflow();
    test_full_pop();
    test_async_reset();
    test_gaps();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
